btn_press_counter: RTL and testbench
====================================

# btn_press_counter

Debounced two-button press counter: the input-side companion of the board's LED counter. Two raw pushbutton inputs are synchronised and debounced on a prescaled sample tick. Each clean press of the up button increments an 8-bit value; each clean press of the down button decrements it. The value and one-cycle press pulses are exported to the display logic.

## Interface
- TICK_DIV, 100000: sample-tick period in clk cycles (≥2); 1 ms at 100 MHz.
- STABLE_SAMPLES, 4: consecutive agreeing samples required to accept a level change (1..15).
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn_up  input  1  raw up button, active-high, asynchronous to clk.
- btn_dn  input  1  raw down button, active-high, asynchronous to clk.
- clr  input  1  synchronous clear of count, active-high.
- count  output  8  current press count.
- up_pulse  output  1  one-cycle strobe per accepted up press.
- dn_pulse  output  1  one-cycle strobe per accepted down press.
- tick  output  1  one-cycle sample strobe (debug/observability).

## Operation
- Synchroniser: each button passes through a 2-FF chain. The debouncer sees only the synchronised level.
- Prescaler: div_cnt runs 0..TICK_DIV-1 and wraps to 0. tick = 1 in the cycle where div_cnt == TICK_DIV-1. The counter is free-running and unaffected by clr.
- Per-button FSM, evaluated only on tick cycles (identical for both buttons):
  - RELEASED: sample = 1 → PRESS_PEND, stable = 1 (if STABLE_SAMPLES == 1, go straight to PRESSED and fire the pulse).
  - PRESS_PEND: sample = 1 → stable + 1; on reaching STABLE_SAMPLES → PRESSED and fire the pulse. Sample = 0 → RELEASED, stable = 0.
  - PRESSED: sample = 0 → REL_PEND, stable = 1 (STABLE_SAMPLES == 1: → RELEASED).
  - REL_PEND: sample = 0 → stable + 1; on reaching STABLE_SAMPLES → RELEASED. Sample = 1 → PRESSED, stable = 0.
  - Non-tick cycles: state and stable counter hold.
- Pulses fire only on entry to PRESSED. Holding a button produces exactly one pulse, with no auto-repeat. Release produces no pulse.
- Count update, applied on the same edge that registers the pulse:
  - clr = 1: count ← 0. Any pulse in the same cycle is still emitted but ignored for counting.
  - Up pulse only: count ← count + 1, mod 256 (0xFF → 0x00).
  - Down pulse only: count ← count − 1, mod 256 (0x00 → 0xFF).
  - Both pulses in the same cycle: count unchanged; both strobes still asserted.
- Reset (asynchronous, any time, including mid-debounce):
  - Synchronisers 0, div_cnt 0, both FSMs RELEASED, stable counters 0.
  - count = 0x00, up_pulse = dn_pulse = tick = 0.
  - A button held through reset release is debounced afresh and produces one pulse once stable.

## Timing
- Input latency: 2 cycles through the synchroniser.
- First tick after reset: cycle TICK_DIV-1 counted from the first active edge after rst falls. Subsequent ticks every TICK_DIV cycles.
- A press is accepted on the edge ending the STABLE_SAMPLES-th consecutive high tick. up_pulse/dn_pulse are high for the following cycle only, and count shows its new value in that same cycle.
- Worst-case press latency: 2 + STABLE_SAMPLES·TICK_DIV cycles. Glitches shorter than one tick period are either unsampled or rejected.
- Minimum inter-press spacing: 2·STABLE_SAMPLES ticks.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset/idle (TICK_DIV=4, STABLE_SAMPLES=3): assert rst mid-cycle with no buttons pressed → count=0x00, pulses 0; tick first high 3 cycles after rst release, then every 4 cycles.
- Clean press: btn_up held high for 40 cycles → exactly one up_pulse, no later than cycle 2+12 after the rise; count=0x01; release produces no pulse.
- Bounce: btn_up toggled high/low each tick for 5 ticks, then low → no pulse, count unchanged; then held high 3+ ticks → one pulse.
- Wrap: 256 clean up presses from 0 → count=0x00; one down press → 0xFF.
- Simultaneous: both buttons rise on the same cycle and are held → up_pulse and dn_pulse high in the same cycle, count unchanged; clr=1 during a pulse cycle → count=0x00.
- Reset mid-operation: rst asserted during PRESS_PEND (after 2 high samples) with btn_up held → count=0 and no pulse during reset; after release, one pulse after 3 new samples, count=0x01.

Source files
------------

// File: rtl/btn_press_counter_if.sv
// Button/count bundle between the raw pushbutton front end and the display logic.
// master drives the buttons and clear; slave is the counter that owns the outputs.
interface btn_press_counter_if;
  logic       btn_up;
  logic       btn_dn;
  logic       clr;
  logic [7:0] count;
  logic       up_pulse;
  logic       dn_pulse;
  logic       tick;

  modport master (
    output btn_up, btn_dn, clr,
    input  count, up_pulse, dn_pulse, tick
  );

  modport slave (
    input  btn_up, btn_dn, clr,
    output count, up_pulse, dn_pulse, tick
  );
endinterface

// File: rtl/btn_press_counter.sv
// Two-button debounced up/down press counter.
// Raw buttons are synchronised, sampled on a prescaled tick, debounced and counted.
module btn_press_counter #(
  parameter int unsigned TICK_DIV       = 100000,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  btn_press_counter_if.slave bus
);

  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned STB_W  = 4;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned N_BTN  = 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(TICK_DIV - 2);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(STABLE_SAMPLES);
  localparam bit               SINGLE   = (STABLE_SAMPLES == 1);

  typedef enum logic [1:0] {
    S_RELEASED   = 2'd0,
    S_PRESS_PEND = 2'd1,
    S_PRESSED    = 2'd2,
    S_REL_PEND   = 2'd3
  } state_t;

  // Index 0 is the up button, index 1 the down button.
  logic [N_BTN-1:0] r_meta;
  logic [N_BTN-1:0] r_sync;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_tick;
  logic             w_tick_nxt;

  state_t           r_state      [N_BTN];
  state_t           w_state_nxt  [N_BTN];
  logic [STB_W-1:0] r_stable     [N_BTN];
  logic [STB_W-1:0] w_stable_nxt [N_BTN];
  logic [N_BTN-1:0] w_fire;
  logic [N_BTN-1:0] r_pulse;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= {bus.btn_dn, bus.btn_up};
      r_sync <= r_meta;
    end
  end

  // Free-running prescaler; tick is registered so it lines up with div_cnt == TICK_DIV-1.
  always_comb begin
    w_div_nxt  = r_div_cnt + DIV_W'(1);
    w_tick_nxt = 1'b0;
    if (r_div_cnt == DIV_LAST) begin
      w_div_nxt = '0;
    end
    if (r_div_cnt == DIV_PRE) begin
      w_tick_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  // Debounce state registers for both buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < N_BTN; b++) begin
        r_state[b]  <= S_RELEASED;
        r_stable[b] <= '0;
      end
    end else begin
      for (int b = 0; b < N_BTN; b++) begin
        r_state[b]  <= w_state_nxt[b];
        r_stable[b] <= w_stable_nxt[b];
      end
    end
  end

  // Debounce next-state: a level change needs STABLE_SAMPLES agreeing ticks.
  always_comb begin
    w_fire = '0;
    for (int b = 0; b < N_BTN; b++) begin
      w_state_nxt[b]  = r_state[b];
      w_stable_nxt[b] = r_stable[b];
      if (r_tick) begin
        case (r_state[b])
          S_RELEASED: begin
            if (r_sync[b]) begin
              if (SINGLE) begin
                w_state_nxt[b]  = S_PRESSED;
                w_stable_nxt[b] = '0;
                w_fire[b]       = 1'b1;
              end else begin
                w_state_nxt[b]  = S_PRESS_PEND;
                w_stable_nxt[b] = STB_W'(1);
              end
            end
          end
          S_PRESS_PEND: begin
            if (r_sync[b]) begin
              if ((r_stable[b] + STB_W'(1)) == STB_MAX) begin
                w_state_nxt[b]  = S_PRESSED;
                w_stable_nxt[b] = '0;
                w_fire[b]       = 1'b1;
              end else begin
                w_stable_nxt[b] = r_stable[b] + STB_W'(1);
              end
            end else begin
              w_state_nxt[b]  = S_RELEASED;
              w_stable_nxt[b] = '0;
            end
          end
          S_PRESSED: begin
            if (!r_sync[b]) begin
              if (SINGLE) begin
                w_state_nxt[b]  = S_RELEASED;
                w_stable_nxt[b] = '0;
              end else begin
                w_state_nxt[b]  = S_REL_PEND;
                w_stable_nxt[b] = STB_W'(1);
              end
            end
          end
          S_REL_PEND: begin
            if (!r_sync[b]) begin
              if ((r_stable[b] + STB_W'(1)) == STB_MAX) begin
                w_state_nxt[b]  = S_RELEASED;
                w_stable_nxt[b] = '0;
              end else begin
                w_stable_nxt[b] = r_stable[b] + STB_W'(1);
              end
            end else begin
              w_state_nxt[b]  = S_PRESSED;
              w_stable_nxt[b] = '0;
            end
          end
          default: begin
            w_state_nxt[b]  = S_RELEASED;
            w_stable_nxt[b] = '0;
          end
        endcase
      end
    end
  end

  // Clear wins; simultaneous up and down presses cancel.
  always_comb begin
    w_count_nxt = r_count;
    if (bus.clr) begin
      w_count_nxt = '0;
    end else if (w_fire == 2'b01) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (w_fire == 2'b10) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_pulse <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_pulse <= w_fire;
    end
  end

  assign bus.count    = r_count;
  assign bus.up_pulse = r_pulse[0];
  assign bus.dn_pulse = r_pulse[1];
  assign bus.tick     = r_tick;

endmodule

// File: tb/tb_btn_press_counter.sv
// Bench for btn_press_counter: cycle-by-cycle behavioural model plus directed scenarios.
module tb_btn_press_counter;

  localparam int unsigned TD  = 4;
  localparam int unsigned STB = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  btn_press_counter_if bif ();

  btn_press_counter #(
    .TICK_DIV       (TD),
    .STABLE_SAMPLES (STB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each button has an accepted level and a run of disagreeing samples.
  logic [1:0] m_meta;
  logic [1:0] m_sync;
  logic [1:0] m_lvl;
  int         m_run [2];
  int         m_cyc;
  logic [7:0] e_count;
  logic       e_up;
  logic       e_dn;
  logic       e_tick;
  bit         m_valid;

  initial m_valid = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    logic [1:0] lvl;
    logic [1:0] fire;
    int         run [2];
    logic [7:0] cnt;
    if (rst) begin
      m_meta  <= '0;
      m_sync  <= '0;
      m_lvl   <= '0;
      m_run   <= '{0, 0};
      m_cyc   <= 0;
      e_count <= '0;
      e_up    <= 1'b0;
      e_dn    <= 1'b0;
      e_tick  <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      lvl  = m_lvl;
      run  = m_run;
      fire = '0;
      if (e_tick) begin
        for (int b = 0; b < 2; b++) begin
          if (m_sync[b] != lvl[b]) begin
            run[b] = run[b] + 1;
            if (run[b] == int'(STB)) begin
              lvl[b]  = m_sync[b];
              run[b]  = 0;
              fire[b] = lvl[b];
            end
          end else begin
            run[b] = 0;
          end
        end
      end
      cnt = e_count;
      if (bif.clr)               cnt = 8'd0;
      else if (fire == 2'b01)    cnt = cnt + 8'd1;
      else if (fire == 2'b10)    cnt = cnt - 8'd1;
      m_lvl   <= lvl;
      m_run   <= run;
      e_count <= cnt;
      e_up    <= fire[0];
      e_dn    <= fire[1];
      m_cyc   <= m_cyc + 1;
      e_tick  <= (((m_cyc + 1) % int'(TD)) == int'(TD) - 1);
      m_sync  <= m_meta;
      m_meta  <= {bif.btn_dn, bif.btn_up};
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_count", 32'(bif.count), 32'(e_count));
      chk("cyc_up",    32'(bif.up_pulse), 32'(e_up));
      chk("cyc_dn",    32'(bif.dn_pulse), 32'(e_dn));
      chk("cyc_tick",  32'(bif.tick), 32'(e_tick));
    end
  end

  // Running totals of observed strobes; scenarios compare deltas against literals.
  int n_up;
  int n_dn;
  int n_both;
  initial begin
    n_up = 0; n_dn = 0; n_both = 0;
  end
  always @(negedge clk) begin
    if (bif.up_pulse) n_up <= n_up + 1;
    if (bif.dn_pulse) n_dn <= n_dn + 1;
    if (bif.up_pulse && bif.dn_pulse) n_both <= n_both + 1;
  end

  task automatic press(input logic up, input logic dn);
    @(negedge clk);
    bif.btn_up = up;
    bif.btn_dn = dn;
    repeat (20) @(negedge clk);
    bif.btn_up = 1'b0;
    bif.btn_dn = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int base_up;
    int base_dn;
    int base_both;
    int lat;
    int nt;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bif.btn_up = 1'b0;
    bif.btn_dn = 1'b0;
    bif.clr    = 1'b0;

    // Reset asserted mid-cycle with idle buttons.
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(bif.count), 32'h00);
    chk("rst_up",    32'(bif.up_pulse), 32'h0);
    chk("rst_dn",    32'(bif.dn_pulse), 32'h0);
    chk("rst_tick",  32'(bif.tick), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("tick_seq", 32'(bif.tick), ((i % 4) == 3) ? 32'h1 : 32'h0);
    end

    // Clean press: one pulse within 2+3*4 cycles, release gives nothing.
    base_up = n_up;
    base_dn = n_dn;
    @(negedge clk);
    bif.btn_up = 1'b1;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bif.up_pulse && lat == 0) lat = i;
    end
    bif.btn_up = 1'b0;
    repeat (20) @(negedge clk);
    chk("press_latency_ok", 32'((lat >= 1) && (lat <= 14)), 32'h1);
    chk("press_one_pulse",  32'(n_up - base_up), 32'd1);
    chk("press_no_dn",      32'(n_dn - base_dn), 32'd0);
    chk("press_count",      32'(bif.count), 32'h01);

    // Bounce: alternate level each tick period, never stable long enough.
    base_up = n_up;
    for (int k = 0; k < 5; k++) begin
      bif.btn_up = ((k % 2) == 0);
      repeat (4) @(negedge clk);
    end
    bif.btn_up = 1'b0;
    repeat (20) @(negedge clk);
    chk("bounce_no_pulse", 32'(n_up - base_up), 32'd0);
    chk("bounce_count",    32'(bif.count), 32'h01);
    press(1'b1, 1'b0);
    chk("bounce_then_hold", 32'(n_up - base_up), 32'd1);
    chk("bounce_count2",    32'(bif.count), 32'h02);

    // Wrap: clear, 256 ups return to zero, one down gives 0xFF.
    @(negedge clk);
    bif.clr = 1'b1;
    @(negedge clk);
    bif.clr = 1'b0;
    chk("clr_count", 32'(bif.count), 32'h00);
    for (int k = 0; k < 256; k++) press(1'b1, 1'b0);
    chk("wrap_up", 32'(bif.count), 32'h00);
    press(1'b0, 1'b1);
    chk("wrap_dn", 32'(bif.count), 32'hFF);

    // Simultaneous presses cancel in the count.
    base_both = n_both;
    press(1'b1, 1'b1);
    chk("simul_both_strobes", 32'(n_both - base_both), 32'd1);
    chk("simul_count",        32'(bif.count), 32'hFF);

    // Clear held across a press: strobe still emitted, count cleared.
    base_up = n_up;
    @(negedge clk);
    bif.clr = 1'b1;
    press(1'b1, 1'b0);
    bif.clr = 1'b0;
    chk("clr_pulse_seen", 32'(n_up - base_up), 32'd1);
    chk("clr_pulse_count", 32'(bif.count), 32'h00);

    // Reset during PRESS_PEND with the button held, then fresh debounce.
    nt = 0;
    for (int i = 0; i < 10 && nt == 0; i++) begin
      @(negedge clk);
      if (bif.tick) nt = 1;
    end
    chk("midrst_tick_found", 32'(nt), 32'd1);
    bif.btn_up = 1'b1;
    nt = 0;
    for (int i = 0; i < 20 && nt < 2; i++) begin
      @(negedge clk);
      if (bif.tick) nt = nt + 1;
    end
    @(negedge clk);
    #1 rst = 1'b1;
    base_up = n_up;
    repeat (3) @(negedge clk);
    chk("midrst_count", 32'(bif.count), 32'h00);
    chk("midrst_up",    32'(bif.up_pulse), 32'h0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_one_pulse", 32'(n_up - base_up), 32'd1);
    chk("midrst_count1",    32'(bif.count), 32'h01);
    bif.btn_up = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
